// File: rtl/fdivsqrt_resid_post4.sv
// fdivsqrt_resid_post4: resolves the final redundant residual of the radix-4 div/sqrt recurrence,
// selects the truncated quotient/root and derives remainder, sign, zero and sticky flags.
module fdivsqrt_resid_post4 #(
    parameter int DIVb = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            InValid,
    output logic            InReady,
    input  logic [DIVb+3:0] WS,
    input  logic [DIVb+3:0] WC,
    input  logic [DIVb:0]   U,
    input  logic [DIVb:0]   UM,
    input  logic [DIVb+3:0] D,
    input  logic            SqrtE,
    input  logic            IntDivE,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [DIVb:0]   Quot,
    output logic [DIVb+3:0] Rem,
    output logic            RemNeg,
    output logic            RemZero,
    output logic            Sticky
);
    typedef enum logic [1:0] {IDLE, SUM, CHECK, HOLD} state_t;
    state_t r_state, w_next;
    logic [DIVb+3:0] r_ws, r_wc, r_d, r_w, r_rem;
    logic [DIVb:0]   r_u, r_um, r_quot;
    logic            r_sqrt, r_int, r_neg, r_zero, r_sticky;
    logic            w_accept, w_neg;
    assign InReady  = (r_state == IDLE);
    assign OutValid = (r_state == HOLD);
    assign w_accept = InReady & InValid & ~FlushE;
    assign w_neg    = r_w[DIVb+3];
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? SUM : IDLE;
            SUM:     w_next = CHECK;
            CHECK:   w_next = HOLD;
            HOLD:    w_next = OutReady ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
        if (FlushE) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ws     <= '0;
            r_wc     <= '0;
            r_d      <= '0;
            r_u      <= '0;
            r_um     <= '0;
            r_sqrt   <= 1'b0;
            r_int    <= 1'b0;
            r_w      <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ws   <= WS;
                r_wc   <= WC;
                r_d    <= D;
                r_u    <= U;
                r_um   <= UM;
                r_sqrt <= SqrtE;
                r_int  <= IntDivE;
            end
            if (r_state == SUM && !FlushE) r_w <= r_ws + r_wc;
            // Only integer divide restores a negative remainder; sqrt residual is passed through raw.
            if (r_state == CHECK && !FlushE) begin
                r_neg    <= w_neg;
                r_zero   <= (r_w == '0);
                r_sticky <= (r_w != '0);
                r_quot   <= w_neg ? r_um : r_u;
                r_rem    <= (r_int & ~r_sqrt & w_neg) ? r_w + r_d : r_w;
            end
        end
    end
    assign Quot    = r_quot;
    assign Rem     = r_rem;
    assign RemNeg  = r_neg;
    assign RemZero = r_zero;
    assign Sticky  = r_sticky;
endmodule

// File: tb/tb_fdivsqrt_resid_post4.sv
// tb_fdivsqrt_resid_post4: directed and random checks of the residual post-processing block (DIVb=8).
module tb_fdivsqrt_resid_post4;
    localparam int DIVb = 8;
    logic clk = 1'b0;
    logic reset, FlushE, InValid, InReady, SqrtE, IntDivE, OutValid, OutReady;
    logic RemNeg, RemZero, Sticky;
    logic [DIVb+3:0] WS, WC, D, Rem;
    logic [DIVb:0]   U, UM, Quot;
    int checks = 0, failures = 0;
    logic [DIVb:0]   e_quot;
    logic [DIVb+3:0] e_rem;
    logic            e_neg, e_zero;

    always #5 clk = ~clk;

    fdivsqrt_resid_post4 #(.DIVb(DIVb)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE), .InValid(InValid), .InReady(InReady),
        .WS(WS), .WC(WC), .U(U), .UM(UM), .D(D), .SqrtE(SqrtE), .IntDivE(IntDivE),
        .OutValid(OutValid), .OutReady(OutReady), .Quot(Quot), .Rem(Rem),
        .RemNeg(RemNeg), .RemZero(RemZero), .Sticky(Sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the 12-bit residual ring.
    task automatic model(input int ws, input int wc, input int u, input int um, input int d,
                         input bit sq, input bit id);
        int w;
        w      = (ws + wc) % 4096;
        e_neg  = (w >= 2048);
        e_zero = (w == 0);
        e_quot = e_neg ? um[DIVb:0] : u[DIVb:0];
        e_rem  = (id && !sq && e_neg) ? ((w + d) % 4096) : w;
    endtask

    task automatic scramble;
        WS = 12'($urandom); WC = 12'($urandom); D = 12'($urandom);
        U = 9'($urandom); UM = 9'($urandom);
        SqrtE = 1'($urandom); IntDivE = 1'($urandom);
    endtask

    task automatic drive(input int ws, input int wc, input int u, input int um, input int d,
                         input bit sq, input bit id);
        WS = 12'(ws); WC = 12'(wc); U = 9'(u); UM = 9'(um); D = 12'(d);
        SqrtE = sq; IntDivE = id; InValid = 1'b1;
    endtask

    task automatic issue(input int ws, input int wc, input int u, input int um, input int d,
                         input bit sq, input bit id);
        chk("in_ready_idle", InReady, 1);
        drive(ws, wc, u, um, d, sq, id);
        model(ws, wc, u, um, d, sq, id);
        tick;
        InValid = 1'b0;
        scramble;
        chk("lat_edge1", OutValid, 0);
        tick;
        chk("lat_edge2", OutValid, 0);
        tick;
        chk("lat_edge3_valid", OutValid, 1);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_quot"}, Quot, e_quot);
        chk({tag, "_rem"}, Rem, e_rem);
        chk({tag, "_neg"}, RemNeg, e_neg);
        chk({tag, "_zero"}, RemZero, e_zero);
        chk({tag, "_sticky"}, Sticky, !e_zero);
        chk({tag, "_inready"}, InReady, 0);
    endtask

    task automatic release_op;
        OutReady = 1'b1;
        tick;
        OutReady = 1'b0;
        chk("release_ov", OutValid, 0);
        chk("release_ir", InReady, 1);
    endtask

    initial begin
        reset = 1'b1; FlushE = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        scramble;
        tick; tick;
        reset = 1'b0;
        chk("rst_inready", InReady, 1);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_quot", Quot, 0);
        chk("rst_rem", Rem, 0);
        chk("rst_sticky", Sticky, 0);
        chk("rst_zero", RemZero, 0);

        issue(12'h010, 12'h000, 9'h155, 9'h154, 12'h100, 0, 1);
        check_out("pos");
        release_op;
        issue(12'hFF0, 12'h000, 9'h155, 9'h154, 12'h100, 0, 1);
        check_out("negcorr");
        release_op;
        issue(12'h123, 12'hEDD, 9'h155, 9'h154, 12'h100, 0, 1);
        check_out("zero");
        release_op;
        issue(12'hFF8, 12'h000, 9'h155, 9'h154, 12'h100, 1, 1);
        check_out("sqrt");
        release_op;
        issue(12'hFF0, 12'h000, 9'h0AA, 9'h0A9, 12'h100, 0, 0);
        check_out("fp_neg");
        release_op;

        issue(12'h7F0, 12'h005, 9'h1FF, 9'h1FE, 12'h333, 0, 1);
        for (int i = 0; i < 5; i++) begin
            InValid = 1'b1;
            drive(12'h001, 12'h001, 9'h001, 9'h000, 12'h001, 0, 0);
            tick;
            InValid = 1'b0;
            chk("bp_valid", OutValid, 1);
            check_out("bp");
        end
        release_op;
        issue(12'h800, 12'h001, 9'h111, 9'h110, 12'h7FF, 0, 1);
        check_out("after_bp");
        release_op;

        for (int i = 0; i < 20; i++) begin
            int hold;
            issue($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 511),
                  $urandom_range(0, 511), $urandom_range(0, 4095), 1'($urandom), 1'($urandom));
            check_out("rand");
            hold = $urandom_range(0, 2);
            for (int k = 0; k < hold; k++) begin
                tick;
                check_out("rand_hold");
            end
            release_op;
        end

        // Flush in CHECK: no output, previous output registers retained.
        drive(12'hFF0, 12'h000, 9'h0F0, 9'h0EF, 12'h100, 0, 1);
        tick;
        InValid = 1'b0;
        tick;
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0;
        chk("flush_chk_ov", OutValid, 0);
        chk("flush_chk_ir", InReady, 1);
        check_out_keep: begin
            chk("flush_keep_quot", Quot, e_quot);
            chk("flush_keep_rem", Rem, e_rem);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("flush_no_ov", OutValid, 0);
        end

        // Flush with InValid in IDLE: nothing captured.
        drive(12'h010, 12'h000, 9'h155, 9'h154, 12'h100, 0, 1);
        FlushE = 1'b1;
        tick;
        FlushE = 1'b0; InValid = 1'b0;
        chk("flush_idle_ir", InReady, 1);
        tick; tick; tick;
        chk("flush_idle_ov", OutValid, 0);

        // Flush in HOLD with OutReady: back to IDLE, outputs unchanged.
        issue(12'h020, 12'h003, 9'h0C3, 9'h0C2, 12'h010, 0, 1);
        check_out("pre_flush_hold");
        FlushE = 1'b1; OutReady = 1'b1;
        tick;
        FlushE = 1'b0; OutReady = 1'b0;
        chk("flush_hold_ov", OutValid, 0);
        chk("flush_hold_ir", InReady, 1);
        chk("flush_hold_quot", Quot, e_quot);

        // Reset in HOLD.
        issue(12'hFF0, 12'h000, 9'h155, 9'h154, 12'h100, 0, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_hold_ov", OutValid, 0);
        chk("rst_hold_quot", Quot, 0);
        chk("rst_hold_rem", Rem, 0);
        chk("rst_hold_ir", InReady, 1);

        // Reset and flush together in HOLD behaves as reset.
        issue(12'h010, 12'h000, 9'h155, 9'h154, 12'h100, 0, 1);
        reset = 1'b1; FlushE = 1'b1;
        tick;
        reset = 1'b0; FlushE = 1'b0;
        chk("rstfl_ov", OutValid, 0);
        chk("rstfl_quot", Quot, 0);
        chk("rstfl_rem", Rem, 0);
        chk("rstfl_sticky", Sticky, 0);
        chk("rstfl_ir", InReady, 1);

        issue(12'h100, 12'h0FF, 9'h042, 9'h041, 12'h005, 0, 1);
        check_out("final");
        release_op;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
